// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake plus PS/2 pin levels and open-drain enables
interface ps2_host_tx_if;
  logic       start;
  logic [7:0] tx_byte;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;
  modport master (
    output start, tx_byte, ps2_clk_in, ps2_data_in,
    input  ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout
  );
  modport slave (
    input  start, tx_byte, ps2_clk_in, ps2_data_in,
    output ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (inhibit, shift, ACK, release)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input logic         clk,
  input logic         reset,
  ps2_host_tx_if.slave bus
);
  localparam int W = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, STOP, ACK, WAIT_IDLE} state_t;
  state_t     state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] sh, sh_n;
  logic       ack, ack_n;
  logic       clk_oe, clk_oe_n, data_oe, data_oe_n, busy, busy_n;
  logic       done, done_n, ack_err, ack_err_n, timeout, timeout_n;
  logic       clk_s1, clk_s2, clk_s3, data_s1, data_s2, fall;
  logic       watch;
  // Sync registers reset high so a released bus never looks like a falling edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      ack     <= 1'b0;
      clk_oe  <= 1'b0;
      data_oe <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      timeout <= 1'b0;
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
      fall    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      sh      <= sh_n;
      ack     <= ack_n;
      clk_oe  <= clk_oe_n;
      data_oe <= data_oe_n;
      busy    <= busy_n;
      done    <= done_n;
      ack_err <= ack_err_n;
      timeout <= timeout_n;
      clk_s1  <= bus.ps2_clk_in;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= bus.ps2_data_in;
      data_s2 <= data_s1;
      fall    <= clk_s3 & ~clk_s2;
    end
  end
  assign watch = state inside {REQ, STOP, ACK, WAIT_IDLE};
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    sh_n      = sh;
    ack_n     = ack;
    clk_oe_n  = clk_oe;
    data_oe_n = data_oe;
    busy_n    = busy;
    done_n    = 1'b0;
    ack_err_n = 1'b0;
    timeout_n = 1'b0;
    if (watch && !fall && cnt == W'(TIMEOUT_CYCLES - 1)) begin
      state_n   = IDLE;
      cnt_n     = '0;
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      busy_n    = 1'b0;
      timeout_n = 1'b0 | 1'b1;
    end else begin
      if (watch) cnt_n = fall ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (bus.start) begin
          state_n   = INHIBIT;
          sh_n      = bus.tx_byte;
          bit_cnt_n = '0;
          cnt_n     = '0;
          busy_n    = 1'b1;
          clk_oe_n  = 1'b1;
        end
        INHIBIT: begin
          cnt_n = cnt + 1'b1;
          if (cnt == W'(INHIBIT_CYCLES - 2)) data_oe_n = 1'b1;
          if (cnt == W'(INHIBIT_CYCLES - 1)) begin
            state_n  = REQ;
            clk_oe_n = 1'b0;
            cnt_n    = '0;
          end
        end
        // Falls 1-8 shift data LSB first, fall 9 drives odd parity
        REQ: if (fall) begin
          data_oe_n = bit_cnt[3] ? ^sh : ~sh[bit_cnt[2:0]];
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt[3]) state_n = STOP;
        end
        STOP: if (fall) begin
          data_oe_n = 1'b0;
          state_n   = ACK;
        end
        ACK: if (fall) begin
          ack_n   = ~data_s2;
          state_n = WAIT_IDLE;
        end
        WAIT_IDLE: if (clk_s2 && data_s2) begin
          done_n    = ack;
          ack_err_n = ~ack;
          busy_n    = 1'b0;
          cnt_n     = '0;
          state_n   = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  assign bus.ps2_clk_oe  = clk_oe;
  assign bus.ps2_data_oe = data_oe;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.ack_err     = ack_err;
  assign bus.timeout     = timeout;
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter, the send-side counterpart to the keyboard receive path (`KeyboardDriver`). It transmits one command byte to the keyboard, for example 0xED (set LEDs) or 0xF4 (enable). It drives the shared PS/2 clock and data lines through open-drain enables and runs the request-to-send, bit-shift, ACK and release sequence. It sits beside the receiver on the same pins. The receiver must ignore traffic while this block reports `busy`.

## Interface
- `INHIBIT_CYCLES`, default 5000: `clk` cycles the host holds PS/2 clock low to request to send. 100 us at 50 MHz.
- `TIMEOUT_CYCLES`, default 750000: maximum `clk` cycles between consecutive PS/2 clock falling edges, and before the first one. 15 ms at 50 MHz.
- `clk`  in  1  system clock; the block's only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `tx_byte`  in  8  command byte; latched on accepted `start`.
- `ps2_clk_in`  in  1  PS/2 clock pin level (asynchronous).
- `ps2_data_in`  in  1  PS/2 data pin level (asynchronous).
- `ps2_clk_oe`  out  1  1 = pull PS/2 clock low; 0 = release.
- `ps2_data_oe`  out  1  1 = pull PS/2 data low; 0 = release.
- `busy`  out  1  high from accepted `start` until return to IDLE.
- `done`  out  1  one-cycle pulse: byte sent and ACK received.
- `ack_err`  out  1  one-cycle pulse: device did not ACK.
- `timeout`  out  1  one-cycle pulse: clock watchdog expired.

## Operation
- Input conditioning:
  - Both pins pass through 2-FF synchronizers.
  - A third register stage produces `fall`, a one-cycle pulse when the synced clock goes 1→0.
- Parity is odd: `~^tx_byte`.
- States, in order:
  - IDLE: both oe = 0.
    - `start` → INHIBIT. Latches `tx_byte`, sets bit counter = 0, sets `busy`.
  - INHIBIT: `ps2_clk_oe`=1.
    - After `INHIBIT_CYCLES` cycles, set `ps2_data_oe`=1 (start bit) → REQ.
  - REQ: on the entry cycle, `ps2_clk_oe`=0 while `ps2_data_oe` stays 1. Watchdog cleared.
    - Each `fall` drives the next bit: `ps2_data_oe` = ~bit.
    - Falls 1–8 drive data bits 0–7, LSB first, counter 0..7.
    - Fall 9 drives parity. State becomes STOP.
  - STOP: fall 10 sets `ps2_data_oe`=0 (stop bit = 1) → ACK.
  - ACK: on fall 11, sample synced data.
    - 0 → WAIT_IDLE, with ack flag set.
    - 1 → WAIT_IDLE, with ack flag clear.
  - WAIT_IDLE: wait until synced clock = 1 and synced data = 1. Then:
    - pulse `done` if ack flag set, else pulse `ack_err`;
    - go to IDLE and clear `busy`.
- Watchdog:
  - Counts in REQ, STOP, ACK and WAIT_IDLE; cleared on every `fall`.
  - Reaching `TIMEOUT_CYCLES`: both oe = 0, pulse `timeout`, go to IDLE and clear `busy`.
- `start` while `busy` is ignored; it is neither queued nor re-latched.
- `tx_byte` changes after acceptance have no effect.
- The output pulses are mutually exclusive. Exactly one pulse fires per accepted `start`.

## Timing
- Reset (asynchronous, any state), all outputs go to 0:
  - `ps2_clk_oe`, `ps2_data_oe`, `busy`, `done`, `ack_err`, `timeout` = 0;
  - state IDLE, counters 0.
  - Reset mid-frame therefore releases both lines immediately.
- `busy` rises the cycle after `start` is sampled. `ps2_clk_oe` rises on the same edge.
- `ps2_clk_oe` stays high for exactly `INHIBIT_CYCLES` cycles.
  - `ps2_data_oe` rises on the last of those cycles.
  - `ps2_clk_oe` falls one cycle later.
- `fall` is asserted 3 `clk` edges after the pin falls. `ps2_data_oe` updates on the edge after `fall`.
  - Total pin-to-pin delay is 4 `clk` cycles. This is well inside the half-period of the 10–16.7 kHz PS/2 clock.
- `done`, `ack_err` and `timeout` are high for exactly 1 cycle. `busy` falls on the same edge.
- A new `start` is accepted on the first cycle back in IDLE.

## Test plan
- Normal send, with `INHIBIT_CYCLES`=10, `TIMEOUT_CYCLES`=2000 and a device model clocking at 20 clk cycles per half-period:
  - stimulus: `tx_byte`=0xED, model ACKs;
  - required: data sampled on model rising edges = 0, 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - required: `done` pulses once, `busy` falls, both oe end at 0.
- Parity and LSB order: `tx_byte`=0xF4 → bits 0,0,1,0,1,1,1,1, parity 0. `tx_byte`=0x00 → parity 1.
- No ACK: the model leaves data high on the 11th clock → `ack_err` pulses once, `done` stays 0, `busy` clears.
- Device silent: no PS/2 clock after the request → `timeout` pulses 2000 cycles after entering REQ, both oe = 0, `busy` clears.
- `start` with 0x55 while sending 0xED → ignored; the frame carries 0xED and only one `done` pulse fires.
- `reset` asserted after data bit 3 → same cycle: both oe = 0, `busy` = 0, no pulses. A subsequent 0xF4 send completes normally.
